// File: rtl/replicated_cnt_fanout_pkg.sv
// Shared configuration and helpers for the replicated modulo counter.
//   DEF_*        default parameter values for the counter and its replicas
//   clog2        ceiling log2, used to size the inject index ports
//   maj_vote     bitwise majority across up to MAX_COPIES replicas
package replicated_cnt_fanout_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_COPIES    = 3;
  localparam int unsigned DEF_MAX       = 9;
  localparam int unsigned DEF_RESET_VAL = 0;

  // Upper bounds the voter function is sized for.
  localparam int unsigned MAX_WIDTH  = 16;
  localparam int unsigned MAX_COPIES = 7;
  localparam int unsigned VW         = MAX_COPIES * MAX_WIDTH;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_CW = clog2(DEF_COPIES);
  localparam int unsigned DEF_BW = clog2(DEF_WIDTH);

  // Bitwise majority: replica c occupies reps[c*width +: width].
  function automatic logic [MAX_WIDTH-1:0] maj_vote(input logic [VW-1:0] reps,
                                                     input int unsigned copies,
                                                     input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    int unsigned          cnt;
    v = '0;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      cnt = 0;
      for (int unsigned c = 0; c < MAX_COPIES; c++) begin
        if (c < copies && b < width) cnt += 32'(reps[c * width + b]);
      end
      v[b] = (cnt > copies / 2);
    end
    return v;
  endfunction

endpackage

// File: rtl/replicated_cnt_fanout_cell.sv
// One counter replica: state flops, fault-inject XOR and compare-to-vote.
//   clk, reset_n   clock, async active-low reset
//   i_nxt          shared next state from the voter
//   i_inj_*        fault inject request (flip one bit when index matches IDX)
//   i_vote         current majority value
//   o_q            this replica's state (registered)
//   o_diff_c       replica disagrees with the vote (combinational)
module replicated_cnt_fanout_cell
  import replicated_cnt_fanout_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RESET_VAL = DEF_RESET_VAL,
  parameter int unsigned IDX       = 0,
  parameter int unsigned CW        = DEF_CW,
  parameter int unsigned BW        = DEF_BW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_nxt,
  input  logic             i_inj_en,
  input  logic [CW-1:0]    i_inj_copy,
  input  logic [BW-1:0]    i_inj_bit,
  input  logic [WIDTH-1:0] i_vote,
  output logic [WIDTH-1:0] o_q,
  output logic             o_diff_c
);

  // Replicas must stay physically distinct so each can drive its own fanout.
  (* keep = "true", dont_merge = "true", dont_touch = "true" *)
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_flip;

  // Out-of-range copy indices never equal IDX; out-of-range bits are masked.
  always_comb begin
    w_flip = '0;
    if (i_inj_en && i_inj_copy == CW'(IDX) && 32'(i_inj_bit) < WIDTH)
      w_flip = WIDTH'(1) << i_inj_bit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= WIDTH'(RESET_VAL);
    else          r_q <= i_nxt ^ w_flip;
  end

  assign o_q      = r_q;
  assign o_diff_c = (r_q != i_vote);

endmodule

// File: rtl/replicated_cnt_fanout.sv
// Modulo-MAX up-counter with COPIES replicated, self-correcting state registers.
//   clk, reset_n      clock, async active-low reset
//   en, load, load_val  count enable / synchronous load (load wins)
//   err_clr           clears sticky error flags (a new mismatch wins)
//   inj_en/copy/bit   fault inject into one replica bit
//   q_rep             raw replica values, replica i at [i*WIDTH +: WIDTH]
//   q_vote, tc, mismatch  combinational vote, terminal count, disagreement
//   err_sticky, err_copy  registered sticky error flags
module replicated_cnt_fanout
  import replicated_cnt_fanout_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned COPIES    = DEF_COPIES,
  parameter  int unsigned MAX       = DEF_MAX,
  parameter  int unsigned RESET_VAL = DEF_RESET_VAL,
  localparam int unsigned CW        = clog2(COPIES),
  localparam int unsigned BW        = clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    err_clr,
  input  logic                    inj_en,
  input  logic [CW-1:0]           inj_copy,
  input  logic [BW-1:0]           inj_bit,
  output logic [COPIES*WIDTH-1:0] q_rep,
  output logic [WIDTH-1:0]        q_vote,
  output logic                    tc,
  output logic                    mismatch,
  output logic                    err_sticky,
  output logic [COPIES-1:0]       err_copy
);

  logic [COPIES*WIDTH-1:0] w_rep;
  logic [COPIES-1:0]       w_diff;
  logic [WIDTH-1:0]        w_vote;
  logic [WIDTH-1:0]        w_nxt;
  logic                    r_err_sticky;
  logic [COPIES-1:0]       r_err_copy;

  // Voter: the only path from replica state back into the shared next state.
  assign w_vote = WIDTH'(maj_vote(VW'(w_rep), COPIES, WIDTH));

  // Values above MAX (only reachable by load) wrap to 0 on the next count.
  always_comb begin
    w_nxt = w_vote;
    if (load)    w_nxt = load_val;
    else if (en) w_nxt = (w_vote >= WIDTH'(MAX)) ? '0 : w_vote + WIDTH'(1);
  end

  for (genvar i = 0; i < COPIES; i++) begin : g_rep
    replicated_cnt_fanout_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL),
      .IDX       (i),
      .CW        (CW),
      .BW        (BW)
    ) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_nxt      (w_nxt),
      .i_inj_en   (inj_en),
      .i_inj_copy (inj_copy),
      .i_inj_bit  (inj_bit),
      .i_vote     (w_vote),
      .o_q        (w_rep[i*WIDTH +: WIDTH]),
      .o_diff_c   (w_diff[i])
    );
  end

  // Sticky error log; a fresh mismatch overrides a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_sticky <= 1'b0;
      r_err_copy   <= '0;
    end else begin
      r_err_sticky <= (|w_diff) | (r_err_sticky & ~err_clr);
      r_err_copy   <= w_diff | (r_err_copy & ~{COPIES{err_clr}});
    end
  end

  assign q_rep      = w_rep;
  assign q_vote     = w_vote;
  assign tc         = (w_vote == WIDTH'(MAX));
  assign mismatch   = |w_diff;
  assign err_sticky = r_err_sticky;
  assign err_copy   = r_err_copy;

endmodule
